fetch_controller: RTL and testbench

Sequences the instruction memory for the RV32I core. It owns the fetch PC, issues one request per instruction and captures the returned word on acknowledge. It holds the word in a one-entry output buffer with a valid/ready handshake toward decode, and applies branch/trap redirects. It sits between the program memory port and the decode stage, and flags a fault on misaligned redirect targets or memory timeout.

---
 rtl/fetch_controller_pkg.sv | 24 ++
 rtl/fetch_timeout_counter.sv | 42 ++++
 rtl/fetch_controller.sv | 123 ++++++++++++
 tb/tb_fetch_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_controller_pkg;

  // Controller states: buffer empty and requesting, buffer full, halted on fault
  typedef enum logic [1:0] {
    FETCH_S_FETCH = 2'd0,
    FETCH_S_HOLD  = 2'd1,
    FETCH_S_FAULT = 2'd2
  } fetch_state_e;

  // RV32I instructions are word aligned; any set bit here marks a bad target
  localparam logic [31:0] FETCH_ALIGN_MASK = 32'h0000_0003;

  // Default fetch address after reset
  localparam logic [31:0] FETCH_DEFAULT_RESET_PC = 32'h0000_0000;

  // Width of the unacknowledged-request counter (covers TIMEOUT up to 255)
  localparam int unsigned FETCH_TIMEOUT_W = 8;

  function automatic logic fetch_is_aligned(input logic [31:0] addr);
    return (addr & FETCH_ALIGN_MASK) == 32'h0000_0000;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts consecutive unacknowledged request cycles
module fetch_timeout_counter
  import fetch_controller_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [FETCH_TIMEOUT_W-1:0] LIMIT_M1 = FETCH_TIMEOUT_W'(LIMIT - 1);

  logic [FETCH_TIMEOUT_W-1:0] count_q;
  logic [FETCH_TIMEOUT_W-1:0] count_d;

  // Expire fires in the cycle whose increment would land on LIMIT, so the
  // fault is registered on that same edge rather than one cycle later.
  assign o_expire = i_enable && !i_clear && (count_q == LIMIT_M1);

  // Next count: clear wins, expiry restarts from zero, otherwise count up
  always_comb begin
    count_d = count_q;
    if (i_clear || o_expire) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - RV32I instruction fetch sequencer with one-entry output buffer
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_pc,
  output logic        o_instruction_request,
  input  logic [31:0] i_instruction,
  input  logic        i_ack,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fetch_fault,
  output logic [31:0] o_fault_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic req;
  logic capture;
  logic expire;

  // A request goes out when the buffer is empty, or is full but drains this
  // cycle. A redirect suppresses it because the current PC is stale, and
  // reset gates it since the state register already reads S_FETCH.
  assign req = i_rst_n && !i_redirect &&
               ((state_q == FETCH_S_FETCH) ||
                ((state_q == FETCH_S_HOLD) && i_ready));

  assign capture = req && i_ack;

  fetch_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (req && !i_ack),
    .i_clear  (i_redirect || capture),
    .o_expire (expire)
  );

  assign o_pc                  = fetch_pc_q;
  assign o_instruction_request = req;
  assign o_valid               = valid_q;
  assign o_instr               = instr_q;
  assign o_instr_pc            = instr_pc_q;
  assign o_fetch_fault         = fault_q;
  assign o_fault_pc            = fault_pc_q;

  // Next-state: redirect beats capture, capture beats timeout, then drain
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    if (i_redirect) begin
      valid_d = 1'b0;
      if (fetch_is_aligned(i_redirect_pc)) begin
        fetch_pc_d = i_redirect_pc;
        state_d    = FETCH_S_FETCH;
        fault_d    = 1'b0;
      end else begin
        state_d    = FETCH_S_FAULT;
        fault_d    = 1'b1;
        fault_pc_d = i_redirect_pc;
      end
    end else if (capture) begin
      instr_d    = i_instruction;
      instr_pc_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
      valid_d    = 1'b1;
      state_d    = FETCH_S_HOLD;
    end else if (expire) begin
      state_d    = FETCH_S_FAULT;
      fault_d    = 1'b1;
      fault_pc_d = fetch_pc_q;
      valid_d    = 1'b0;
    end else if ((state_q == FETCH_S_HOLD) && i_ready) begin
      // Decode took the word but memory has not answered the next one yet
      valid_d = 1'b0;
      state_d = FETCH_S_FETCH;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= FETCH_S_FETCH;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
module tb_fetch_controller;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        req;
  logic [31:0] instr_in;
  logic        ack;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ready;
  logic        redir;
  logic [31:0] rpc;
  logic        fault;
  logic [31:0] fpc;

  int n_vec;
  int n_err;

  // Reference model: buffer-full flag, halted flag, fetch address, miss count
  logic [31:0] m_pc, m_instr, m_ipc, m_fpc;
  bit          m_valid, m_fault;
  int          m_miss;

  fetch_controller #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .o_pc                  (pc),
    .o_instruction_request (req),
    .i_instruction         (instr_in),
    .i_ack                 (ack),
    .o_valid               (valid),
    .o_instr               (instr),
    .o_instr_pc            (ipc),
    .i_ready               (ready),
    .i_redirect            (redir),
    .i_redirect_pc         (rpc),
    .o_fetch_fault         (fault),
    .o_fault_pc            (fpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0013_0013;
  endfunction

  function automatic logic m_req();
    return rst_n && !redir && !m_fault && (!m_valid || ready);
  endfunction

  function automatic logic [130:0] exp_vec();
    return {m_pc, m_req(), m_valid, m_instr, m_ipc, m_fault, m_fpc};
  endfunction

  function automatic logic [130:0] act_vec();
    return {pc, req, valid, instr, ipc, fault, fpc};
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 0; m_ipc = 0; m_fpc = 0;
    m_valid = 0; m_fault = 0; m_miss = 0;
  endtask

  // Apply inputs for this cycle (called at the falling edge), settle 1 time unit
  task automatic drive(input logic r, input logic [31:0] rp, input logic a, input logic rd);
    redir = r; rpc = rp; ack = a; ready = rd;
    instr_in = mem_word(m_pc);
    #1;
  endtask

  // Advance one clock and move the model by the same rules
  task automatic tick();
    logic rq;
    rq = m_req();
    @(posedge clk);
    if (rst_n) begin
      if (redir) begin
        m_valid = 0;
        m_miss  = 0;
        if (rpc[1:0] == 2'b00) begin
          m_pc = rpc; m_fault = 0;
        end else begin
          m_fault = 1; m_fpc = rpc;
        end
      end else if (rq && ack) begin
        m_instr = mem_word(m_pc);
        m_ipc   = m_pc;
        m_pc    = m_pc + 32'd4;
        m_valid = 1;
        m_miss  = 0;
      end else if (rq) begin
        m_miss  = m_miss + 1;
        m_valid = 0;
        if (m_miss == TO) begin
          m_fault = 1; m_fpc = m_pc; m_miss = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; redir = 0; ack = 0; ready = 0; rpc = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; redir = 0; ack = 1; ready = 1; rpc = 0; instr_in = 32'hDEAD_BEEF;
    model_reset();
    #12;
    n_vec++;
    if (req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", req); end
    n_vec++;
    if (act_vec() !== {RST_PC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_state got=%h want=%h", act_vec(), {RST_PC, 99'h0});
    end
  endtask

  task automatic test_sequence();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1);
      n_vec++;
      if ({pc, req} !== {32'(4 * i), 1'b1}) begin
        n_err++; $display("FAIL seq_req[%0d] got pc=%h req=%b want pc=%h req=1", i, pc, req, 4 * i);
      end
      if (i > 0) begin
        n_vec++;
        if ({valid, ipc, instr} !== {1'b1, 32'(4 * (i - 1)), mem_word(32'(4 * (i - 1)))}) begin
          n_err++; $display("FAIL seq_out[%0d] got v=%b pc=%h ins=%h want pc=%h", i, valid, ipc, instr, 4 * (i - 1));
        end
      end
      tick();
    end
    drive(0, 0, 1, 1);
    n_vec++;
    if ({valid, ipc} !== {1'b1, 32'h8}) begin
      n_err++; $display("FAIL seq_last got v=%b pc=%h want v=1 pc=00000008", valid, ipc);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(0, 0, 1, 1); tick();
    drive(0, 0, 1, 1); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0);
      n_vec++;
      if ({req, valid, ipc, instr, pc} !== {1'b0, 1'b1, 32'h4, mem_word(32'h4), 32'h8}) begin
        n_err++; $display("FAIL bp_hold[%0d] got req=%b v=%b ipc=%h ins=%h pc=%h want req=0 v=1 ipc=4 pc=8",
                          k, req, valid, ipc, instr, pc);
      end
      tick();
    end
    drive(0, 0, 1, 1);
    n_vec++;
    if ({req, pc} !== {1'b1, 32'h8}) begin
      n_err++; $display("FAIL bp_release got req=%b pc=%h want req=1 pc=00000008", req, pc);
    end
    tick();
    drive(0, 0, 1, 1);
    n_vec++;
    if (ipc !== 32'h8) begin n_err++; $display("FAIL bp_next got=%h want=00000008", ipc); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 1); tick(); end
    drive(1, 32'h100, 1, 1);
    n_vec++;
    if ({req, valid, ipc} !== {1'b0, 1'b1, 32'h8}) begin
      n_err++; $display("FAIL redir_cycle got req=%b v=%b ipc=%h want req=0 v=1 ipc=8", req, valid, ipc);
    end
    tick();
    drive(0, 0, 1, 1);
    n_vec++;
    if ({valid, pc, req} !== {1'b0, 32'h100, 1'b1}) begin
      n_err++; $display("FAIL redir_target got v=%b pc=%h req=%b want v=0 pc=100 req=1", valid, pc, req);
    end
    tick();
    drive(0, 0, 1, 1);
    n_vec++;
    if ({valid, ipc} !== {1'b1, 32'h100}) begin
      n_err++; $display("FAIL redir_first got v=%b ipc=%h want v=1 ipc=100", valid, ipc);
    end
  endtask

  task automatic test_fault_redirect();
    drive(1, 32'h102, 1, 1); tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 1);
      n_vec++;
      if ({fault, fpc, req, valid} !== {1'b1, 32'h102, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL misalign[%0d] got f=%b fpc=%h req=%b v=%b want f=1 fpc=102 req=0 v=0",
                          k, fault, fpc, req, valid);
      end
      tick();
    end
    drive(1, 32'h200, 1, 1); tick();
    drive(0, 0, 1, 1);
    n_vec++;
    if ({fault, pc, req} !== {1'b0, 32'h200, 1'b1}) begin
      n_err++; $display("FAIL fault_exit got f=%b pc=%h req=%b want f=0 pc=200 req=1", fault, pc, req);
    end
    tick();
    drive(0, 0, 1, 1);
    n_vec++;
    if (ipc !== 32'h200) begin n_err++; $display("FAIL fault_resume got=%h want=00000200", ipc); end
  endtask

  task automatic test_timeout();
    drive(1, 32'h40, 0, 1); tick();
    for (int k = 0; k < TO; k++) begin
      drive(0, 0, 0, 1);
      n_vec++;
      if ({req, fault, pc} !== {1'b1, 1'b0, 32'h40}) begin
        n_err++; $display("FAIL to_wait[%0d] got req=%b f=%b pc=%h want req=1 f=0 pc=40", k, req, fault, pc);
      end
      tick();
    end
    drive(0, 0, 0, 1);
    n_vec++;
    if ({fault, fpc, req, valid} !== {1'b1, 32'h40, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL to_fault got f=%b fpc=%h req=%b v=%b want f=1 fpc=40 req=0 v=0", fault, fpc, req, valid);
    end
    // An ack one short of the limit restarts the count
    drive(1, 32'h80, 0, 1); tick();
    for (int k = 0; k < TO - 1; k++) begin drive(0, 0, 0, 1); tick(); end
    drive(0, 0, 1, 1); tick();
    for (int k = 0; k < TO - 1; k++) begin drive(0, 0, 0, 1); tick(); end
    drive(0, 0, 0, 1);
    n_vec++;
    if ({fault, req, pc} !== {1'b0, 1'b1, 32'h84}) begin
      n_err++; $display("FAIL to_restart got f=%b req=%b pc=%h want f=0 req=1 pc=84", fault, req, pc);
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 1, 0);
    n_vec++;
    if ({valid, ipc} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL rh_hold got v=%b ipc=%h want v=1 ipc=0", valid, ipc);
    end
    drive(1, 32'h300, 1, 1);
    #1 rst_n = 0;
    model_reset();
    #1;
    n_vec++;
    if ({valid, req, pc, instr, ipc} !== {1'b0, 1'b0, RST_PC, 32'h0, 32'h0}) begin
      n_err++; $display("FAIL rh_async got v=%b req=%b pc=%h ins=%h ipc=%h want all zero", valid, req, pc, instr, ipc);
    end
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 1, 1);
    n_vec++;
    if ({pc, req} !== {RST_PC, 1'b1}) begin
      n_err++; $display("FAIL rh_restart got pc=%h req=%b want pc=%h req=1", pc, req, RST_PC);
    end
    tick();
  endtask

  task automatic test_random();
    logic        r, a, rd;
    logic [31:0] rp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 11) == 0);
      rp = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      if (i >= 300 && i < 420) a = ($urandom_range(0, 9) < 3);
      else                     a = ($urandom_range(0, 9) < 8);
      rd = ($urandom_range(0, 3) != 0);
      drive(r, rp, a, rd);
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d] got=%h want=%h", i, act_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_sequence();
    test_backpressure();
    test_redirect();
    test_fault_redirect();
    test_timeout();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
